// File: rtl/fpadd_issue_stage_if.sv
// Handshake bundle for fpadd_issue_stage: the upstream operand stream and the
// downstream result stream. The stage connects through the slave modport.
interface fpadd_issue_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [2:0]  out_flags;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result, out_flags
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result, out_flags
    );
endinterface

// File: rtl/fpadd_issue_stage.sv
// Issue/capture stage around an external combinational FP32 adder.
// Operand pairs are queued in a FIFO, sanitized (zero/subnormal -> +0) and
// either sent to the adder (one EXEC cycle) or resolved directly when an
// operand is Inf/NaN. Results are held in OUT until downstream accepts them.
module fpadd_issue_stage #(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    fpadd_issue_stage_if.slave      bus,
    output logic [31:0]             add_a,
    output logic [31:0]             add_b,
    input  logic [31:0]             add_result,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        OUT
    } state_t;

    state_t state, next_state;

    logic [63:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    // Head-of-queue classification
    logic [31:0] head_a, head_b;
    logic [31:0] san_a, san_b;
    logic        flush;
    logic        head_special;
    logic [31:0] bypass_result;
    logic [2:0]  bypass_flags;

    // Zero-exponent operands (zero or subnormal, either sign) become +0.
    function automatic logic [31:0] sanitize(input logic [31:0] x);
        return (x[30:23] == 8'h00) ? 32'h0000_0000 : x;
    endfunction

    function automatic logic is_subnormal(input logic [31:0] x);
        return (x[30:23] == 8'h00) && (x[22:0] != 23'h0);
    endfunction

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
    endfunction

    function automatic logic is_inf(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] == 23'h0);
    endfunction

    assign push         = bus.in_valid && bus.in_ready;
    assign pop          = (count != '0) &&
                          ((state == IDLE) || ((state == OUT) && bus.out_ready));
    assign bus.in_ready = !reset && (count < FULL);
    assign bus.out_valid = (state == OUT);

    assign head_a       = mem[rd_ptr][63:32];
    assign head_b       = mem[rd_ptr][31:0];
    assign san_a        = sanitize(head_a);
    assign san_b        = sanitize(head_b);
    assign flush        = is_subnormal(head_a) || is_subnormal(head_b);
    assign head_special = (head_a[30:23] == 8'hFF) || (head_b[30:23] == 8'hFF);

    // Resolve Inf/NaN pairs without the adder.
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        bypass_result = QNAN;
        bypass_flags  = {flush, 2'b01};
        if (is_nan(head_a) || is_nan(head_b) ||
            (is_inf(head_a) && is_inf(head_b) && (head_a[31] != head_b[31]))) begin
            bypass_result = QNAN;
            bypass_flags  = {flush, 2'b01};
        end else if (is_inf(head_a)) begin
            bypass_result = head_a;
            bypass_flags  = {flush, 2'b10};
        end else begin
            bypass_result = head_b;
            bypass_flags  = {flush, 2'b10};
        end
    end

    // FSM state register.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state: a pop issues the head pair, otherwise EXEC drains to OUT
    // and an accepted result with an empty queue returns to IDLE.
    always_comb begin
        next_state = state;
        if (pop) begin
            next_state = head_special ? OUT : EXEC;
        end else begin
            case (state)
                IDLE:    next_state = IDLE;
                EXEC:    next_state = OUT;
                OUT:     next_state = bus.out_ready ? IDLE : OUT;
                default: next_state = IDLE;
            endcase
        end
    end

    // Operand storage written on push.
    // NOTE: the storage array is not reset; count and pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.in_a, bus.in_b};
        end
    end

    // FIFO pointers/occupancy, adder operand registers and result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            add_a          <= '0;
            add_b          <= '0;
            bus.out_result <= '0;
            bus.out_flags  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (pop) begin
                if (head_special) begin
                    bus.out_result <= bypass_result;
                    bus.out_flags  <= bypass_flags;
                end else begin
                    add_a         <= san_a;
                    add_b         <= san_b;
                    bus.out_flags <= {flush, 2'b00};
                end
            end else if (state == EXEC) begin
                bus.out_result <= add_result;
            end
        end
    end
endmodule

// File: tb/tb_fpadd_issue_stage.sv
// Directed testbench for fpadd_issue_stage. A lookup-table adder stands in
// for the combinational FP32 adder, covering only the operand pairs used here.
module tb_fpadd_issue_stage;
    logic        clk;
    logic        reset;
    logic [31:0] add_a, add_b, add_result;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;

    fpadd_issue_stage_if bus ();

    fpadd_issue_stage #(.DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_result (add_result),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-computed sums for the sanitized pairs exercised below.
    function automatic logic [31:0] adder_model(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h3F80_0000, 32'h4000_0000}: return 32'h4040_0000;
            {32'h3F80_0000, 32'h3F80_0000}: return 32'h4000_0000;
            {32'h0000_0000, 32'h3F80_0000}: return 32'h3F80_0000;
            {32'h0000_0000, 32'h4000_0000}: return 32'h4000_0000;
            {32'h4040_0000, 32'hC040_0000}: return 32'h0000_0000;
            default:                        return 32'hDEAD_BEEF;
        endcase
    endfunction

    assign add_result = adder_model(add_a, add_b);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pair(input logic [31:0] a, input logic [31:0] b);
        check("push_ready", {31'b0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Wait (bounded) for a result, compare it, then accept it.
    task automatic wait_result(input string tag, input logic [31:0] exp_res, input logic [2:0] exp_flags);
        int n = 0;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, {31'b0, bus.out_valid}, 32'd1);
        check({tag, "_result"}, bus.out_result, exp_res);
        check({tag, "_flags"}, {29'b0, bus.out_flags}, {29'b0, exp_flags});
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int accepted;
        int nres;
        int cyc;
        int idx [5];
        int seen;

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
        reset = 1'b0;
        #1;
        check("rst_count", {29'b0, count}, 32'd0);
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_out_result", bus.out_result, 32'd0);
        check("rst_flags", {29'b0, bus.out_flags}, 32'd0);
        check("rst_add_a", add_a, 32'd0);
        check("rst_add_b", add_b, 32'd0);
        check("rst_in_ready_after", {31'b0, bus.in_ready}, 32'd1);

        // Basic add with latency: push at edge k, pop k+1, valid after k+2
        push_pair(32'h3F80_0000, 32'h4000_0000);
        check("basic_valid_k", {31'b0, bus.out_valid}, 32'd0);
        tick();
        check("basic_valid_k1", {31'b0, bus.out_valid}, 32'd0);
        check("basic_add_a", add_a, 32'h3F80_0000);
        check("basic_add_b", add_b, 32'h4000_0000);
        tick();
        check("basic_valid_k2", {31'b0, bus.out_valid}, 32'd1);
        wait_result("basic", 32'h4040_0000, 3'b000);
        check("basic_idle", {31'b0, bus.out_valid}, 32'd0);

        // Specials: bypass path, valid one edge after pop, adder operands untouched
        push_pair(32'h7F80_0000, 32'hFF80_0000);
        tick();
        check("inf_inf_valid_k1", {31'b0, bus.out_valid}, 32'd1);
        check("inf_inf_add_a", add_a, 32'h3F80_0000);
        wait_result("inf_inf", 32'h7FC0_0000, 3'b001);

        push_pair(32'hFF80_0000, 32'h3F80_0000);
        tick();
        check("ninf_valid_k1", {31'b0, bus.out_valid}, 32'd1);
        check("ninf_add_b", add_b, 32'h4000_0000);
        wait_result("ninf", 32'hFF80_0000, 3'b010);

        // Sanitize: subnormal flushed with flag, -0 canonicalized without flag
        push_pair(32'h0000_0001, 32'h3F80_0000);
        wait_result("subn", 32'h3F80_0000, 3'b100);
        check("subn_add_a", add_a, 32'h0000_0000);

        push_pair(32'h8000_0000, 32'h4000_0000);
        wait_result("negz", 32'h4000_0000, 3'b000);
        check("negz_add_a", add_a, 32'h0000_0000);

        // Cancellation
        push_pair(32'h4040_0000, 32'hC040_0000);
        wait_result("cancel", 32'h0000_0000, 3'b000);

        // Backpressure: stream 8 pairs with out_ready low
        accepted = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.in_ready) accepted++;
            bus.in_valid = 1'b1;
            bus.in_a     = 32'h3F80_0000;
            bus.in_b     = 32'h3F80_0000;
            tick();
        end
        bus.in_valid = 1'b0;
        check("bp_accepted", accepted, 32'd5);
        check("bp_count", {29'b0, count}, 32'd4);
        check("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);

        // Drain in order with out_ready held high
        bus.out_ready = 1'b1;
        nres = 0;
        cyc  = 0;
        while (nres < 5 && cyc < 40) begin
            if (bus.out_valid) begin
                check("bp_result", bus.out_result, 32'h4000_0000);
                idx[nres] = cyc;
                nres++;
            end
            tick();
            cyc++;
        end
        bus.out_ready = 1'b0;
        check("bp_nresults", nres, 32'd5);
        check("bp_count_drained", {29'b0, count}, 32'd0);
        check("bp_gap", idx[2] - idx[1], 32'd2);
        check("bp_idle", {31'b0, bus.out_valid}, 32'd0);

        // Reset mid-stream: one result in OUT, three pairs queued
        for (int i = 0; i < 4; i++) push_pair(32'h3F80_0000, 32'h3F80_0000);
        check("mid_count", {29'b0, count}, 32'd3);
        check("mid_valid", {31'b0, bus.out_valid}, 32'd1);
        reset = 1'b1;
        tick();
        check("mid_rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
        reset = 1'b0;
        #1;
        check("mid_rst_count", {29'b0, count}, 32'd0);
        check("mid_rst_valid", {31'b0, bus.out_valid}, 32'd0);
        check("mid_rst_result", bus.out_result, 32'd0);
        tick();
        check("mid_post_valid", {31'b0, bus.out_valid}, 32'd0);

        push_pair(32'h3F80_0000, 32'h4000_0000);
        wait_result("mid_new", 32'h4040_0000, 3'b000);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.out_valid) seen++;
            tick();
        end
        check("mid_no_stale", seen, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fpadd_issue_stage.md
# fpadd_issue_stage

Stream front-end and result-capture stage wrapped around the combinational single-cycle FP32 adder. It accepts operand pairs over a valid/ready handshake and buffers them in a FIFO. Before issue, it sanitizes each pair so the adder only ever sees normal numbers or +0. It captures the adder's result and presents it downstream with backpressure, and resolves NaN/Inf cases by bypass without using the adder.

## Interface
- DEPTH, 4: operand FIFO entries; power of two, ≥2.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  stage can accept a pair.
- in_a  in  32  FP32 operand A.
- in_b  in  32  FP32 operand B.
- add_a  out  32  registered operand driven to adder reg_A.
- add_b  out  32  registered operand driven to adder reg_B.
- add_result  in  32  adder result (combinational from add_a/add_b).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_result  out  32  FP32 sum.
- out_flags  out  3  [0] NaN produced, [1] Inf produced, [2] ≥1 subnormal operand flushed.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- FIFO: push on in_valid && in_ready; in_ready = !reset && count < DEPTH.
  - No push when full, even if a pop occurs in the same cycle.
  - Simultaneous push and pop below full leaves count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, EXEC, OUT.
- Pop condition: FIFO non-empty and (state == IDLE, or state == OUT with out_ready). On pop, classify the head pair.
- Sanitize each operand:
  - exp==0 (any mantissa, either sign) → 32'h00000000.
  - If mantissa ≠ 0, also set flag[2].
  - -0 is always canonicalized to +0.
- Special pairs (either operand has exp==255) bypass the adder:
  - Any NaN, or +Inf with -Inf → out_result 32'h7FC00000, flag[0].
  - Otherwise → the Inf operand (sign preserved), flag[1].
  - FSM goes directly to OUT.
- Normal pairs: load add_a/add_b with the sanitized operands and go to EXEC.
- EXEC (exactly one cycle): capture add_result into out_result, go to OUT. add_a/add_b hold until the next pop.
- OUT: out_valid = 1. out_result/out_flags stay stable until the handshake.
  - On out_valid && out_ready: pop and issue the next pair if available, else go to IDLE.
- Results leave in push order.

## Timing
- Reset: state IDLE, FIFO empty, count 0, out_valid 0, out_result 0, out_flags 0, add_a 0, add_b 0, in_ready 0 while reset is high.
- Reset mid-operation discards the FIFO contents and any in-flight result. No out_valid in the cycle after reset.
- Latency from push at edge k with an empty, idle stage:
  - Pop at edge k+1.
  - Normal path: out_valid high after edge k+2.
  - Bypass path: out_valid high after edge k+1.
- Throughput with out_ready held 1:
  - Normal path: one result per 2 cycles.
  - Bypass path: one per cycle.
- out_ready held 0: the stage absorbs exactly DEPTH+1 pairs (DEPTH in the FIFO, 1 in OUT), then holds in_ready low.
- out_ready has no combinational path to in_ready.

## Test plan
- Basic add: push 3F800000 + 40000000 at edge k → out_valid after k+2, out_result 40400000, flags 000.
- Backpressure: out_ready=0 while streaming 8 pairs of 3F800000+3F800000 → exactly 5 accepted, count=4, in_ready=0. Then raise out_ready → five results of 40000000 in order, and count returns to 0.
- Specials:
  - 7F800000 + FF800000 → 7FC00000, flag[0].
  - FF800000 + 3F800000 → FF800000, flag[1].
  - Neither case drives add_a/add_b.
- Sanitize:
  - 00000001 + 3F800000 → add_a = 00000000, out_result 3F800000, flag[2].
  - 80000000 + 40000000 → add_a = 00000000, out_result 40000000, flags 000.
- Cancellation: 40400000 + C0400000 → out_result 00000000.
- Reset mid-stream: 3 pairs queued with one in OUT, assert reset for 1 cycle → count 0, out_valid 0. No stale result appears after new pushes.
